// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic_simulation front end.
// Holds the emergency lane state encoding and the controller light-mode encoding.
package traffic_pkg;

   localparam int unsigned NUM_ROADS = 4;

   localparam logic [1:0] ROAD0 = 2'd0;
   localparam logic [1:0] ROAD1 = 2'd1;
   localparam logic [1:0] ROAD2 = 2'd2;
   localparam logic [1:0] ROAD3 = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      DBNC,
      PEND,
      SERV,
      COOL
   } lane_state_t;

   typedef enum logic {
      GO_MODE,
      CAUTION_MODE
   } light_mode_t;

   // Counter width for a terminal count P; a zero count still needs one bit.
   function automatic int unsigned cnt_width(input int unsigned p);
      return (p == 0) ? 1 : $clog2(p + 1);
   endfunction

endpackage

// File: rtl/emergency_lane.sv
// One road's siren debounce / request / service-hold / cooldown FSM.
// Also tracks how long the request has waited and raises a sticky starved flag.
module emergency_lane
   import traffic_pkg::*;
#(
   parameter int unsigned ROAD         = 0,
   parameter int unsigned DEBOUNCE_CYC = 3,
   parameter int unsigned HOLD_CYC     = 4,
   parameter int unsigned COOLDOWN_CYC = 8,
   parameter int unsigned TIMEOUT_CYC  = 200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       siren,
   input  logic [1:0] current_free_path,
   input  logic       clear_starved,
   output logic       emergency,
   output logic       served,
   output logic       starved
);

   localparam int unsigned DW = cnt_width(DEBOUNCE_CYC);
   localparam int unsigned HW = cnt_width(HOLD_CYC);
   localparam int unsigned CW = cnt_width(COOLDOWN_CYC);
   localparam int unsigned WW = cnt_width(TIMEOUT_CYC);

   localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CYC);
   localparam logic [HW-1:0] H_MAX = HW'(HOLD_CYC);
   localparam logic [CW-1:0] C_MAX = CW'(COOLDOWN_CYC);
   localparam logic [WW-1:0] W_MAX = WW'(TIMEOUT_CYC);

   lane_state_t   state_q, state_d;
   logic [DW-1:0] dcnt_q, dcnt_d, dcnt_inc;
   logic [HW-1:0] hcnt_q, hcnt_d, hcnt_inc;
   logic [CW-1:0] ccnt_q, ccnt_d, ccnt_inc;
   logic [WW-1:0] wcnt_q, wcnt_d, wcnt_inc;
   logic          served_q, served_d;
   logic          starved_q, starved_d;
   logic          emergency_q, emergency_d;
   logic          granted;
   logic          done;

   assign granted  = (current_free_path == 2'(ROAD));
   assign dcnt_inc = dcnt_q + DW'(1);
   assign hcnt_inc = hcnt_q + HW'(1);
   assign ccnt_inc = ccnt_q + CW'(1);
   assign wcnt_inc = wcnt_q + WW'(1);

   always_comb begin
      state_d   = state_q;
      dcnt_d    = dcnt_q;
      hcnt_d    = hcnt_q;
      ccnt_d    = ccnt_q;
      wcnt_d    = wcnt_q;
      served_d  = 1'b0;
      starved_d = starved_q & ~clear_starved;
      done      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (siren) begin
               if (DEBOUNCE_CYC == 1) begin
                  state_d = PEND;
                  wcnt_d  = '0;
               end else begin
                  state_d = DBNC;
                  dcnt_d  = DW'(1);
               end
            end
         end
         DBNC: begin
            if (!siren) begin
               state_d = IDLE;
            end else begin
               dcnt_d = dcnt_inc;
               if (dcnt_inc == D_MAX) begin
                  state_d = PEND;
                  wcnt_d  = '0;
               end
            end
         end
         PEND: begin
            if (granted) begin
               hcnt_d = HW'(1);
               if (HOLD_CYC == 1) begin
                  done = 1'b1;
               end else begin
                  state_d = SERV;
               end
            end
         end
         SERV: begin
            if (!granted) begin
               state_d = PEND;
            end else begin
               hcnt_d = hcnt_inc;
               if (hcnt_inc == H_MAX) begin
                  done = 1'b1;
               end
            end
         end
         COOL: begin
            ccnt_d = ccnt_inc;
            if (ccnt_inc == C_MAX) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (done) begin
         served_d = 1'b1;
         ccnt_d   = '0;
         state_d  = (COOLDOWN_CYC == 0) ? IDLE : COOL;
      end

      // Wait time accrues while requesting, including the completing grant cycle.
      if ((state_q == PEND || state_q == SERV) && wcnt_q != W_MAX) begin
         wcnt_d = wcnt_inc;
         if (wcnt_inc == W_MAX) begin
            starved_d = 1'b1;
         end
      end
   end

   assign emergency_d = (state_d == PEND) || (state_d == SERV);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         dcnt_q      <= '0;
         hcnt_q      <= '0;
         ccnt_q      <= '0;
         wcnt_q      <= '0;
         served_q    <= 1'b0;
         starved_q   <= 1'b0;
         emergency_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         dcnt_q      <= dcnt_d;
         hcnt_q      <= hcnt_d;
         ccnt_q      <= ccnt_d;
         wcnt_q      <= wcnt_d;
         served_q    <= served_d;
         starved_q   <= starved_d;
         emergency_q <= emergency_d;
      end
   end

   assign emergency = emergency_q;
   assign served    = served_q;
   assign starved   = starved_q;

endmodule

// File: rtl/emergency_request_ctrl.sv
// Emergency request front end for traffic_simulation: one independent lane per road,
// producing the latched emergency[3:0] request vector plus served/starved status.
module emergency_request_ctrl
   import traffic_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = 3,
   parameter int unsigned HOLD_CYC     = 4,
   parameter int unsigned COOLDOWN_CYC = 8,
   parameter int unsigned TIMEOUT_CYC  = 200
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_ROADS-1:0] siren,
   input  logic [1:0]           current_free_path,
   input  logic                 clear_starved,
   output logic [NUM_ROADS-1:0] emergency,
   output logic [NUM_ROADS-1:0] served,
   output logic [NUM_ROADS-1:0] starved
);

   for (genvar i = 0; i < NUM_ROADS; i++) begin : g_lane
      emergency_lane #(
         .ROAD         (i),
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .HOLD_CYC     (HOLD_CYC),
         .COOLDOWN_CYC (COOLDOWN_CYC),
         .TIMEOUT_CYC  (TIMEOUT_CYC)
      ) u_lane (
         .clk               (clk),
         .reset             (reset),
         .siren             (siren[i]),
         .current_free_path (current_free_path),
         .clear_starved     (clear_starved),
         .emergency         (emergency[i]),
         .served            (served[i]),
         .starved           (starved[i])
      );
   end

endmodule

// File: tb/tb_emergency_request_ctrl.sv
// Scoreboard bench for emergency_request_ctrl: directed scenarios push expected output
// changes (edge number + value); a monitor pops and compares on every output change.
module tb_emergency_request_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] siren = 4'b0;
   logic [1:0] path = 2'd0;
   logic       clr = 1'b0;
   logic [3:0] emergency, served, starved;

   emergency_request_ctrl #(
      .DEBOUNCE_CYC (3),
      .HOLD_CYC     (4),
      .COOLDOWN_CYC (8),
      .TIMEOUT_CYC  (20)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .siren             (siren),
      .current_free_path (path),
      .clear_starved     (clr),
      .emergency         (emergency),
      .served            (served),
      .starved           (starved)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         edge_n;
      logic [3:0] em;
      logic [3:0] sv;
      logic [3:0] st;
   } exp_t;

   exp_t  q[$];
   int    edge_cnt = 0;
   int    n_pass = 0;
   int    n_total = 0;
   bit    mon_en = 1'b0;
   logic [11:0] prev = '0;
   logic [11:0] cur;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input bit ok, input string act, input string req);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: actual %s, required %s", name, act, req);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_at(input int e, input logic [3:0] em, input logic [3:0] sv,
                            input logic [3:0] st);
      exp_t x;
      x.edge_n = e;
      x.em     = em;
      x.sv     = sv;
      x.st     = st;
      q.push_back(x);
   endtask

   // Output-change monitor.
   always @(negedge clk) begin
      exp_t x;
      cur = {emergency, served, starved};
      if (mon_en && cur !== prev) begin
         if (q.size() == 0) begin
            check("unexpected_change", 1'b0,
                  $sformatf("edge %0d em=%b sv=%b st=%b", edge_cnt, emergency, served, starved),
                  "no change");
         end else begin
            x = q.pop_front();
            check("output_event",
                  (x.edge_n == edge_cnt) && (cur === {x.em, x.sv, x.st}),
                  $sformatf("edge %0d em=%b sv=%b st=%b", edge_cnt, emergency, served, starved),
                  $sformatf("edge %0d em=%b sv=%b st=%b", x.edge_n, x.em, x.sv, x.st));
         end
      end
      prev = cur;
   end

   initial begin
      int e;
      int s;
      int rises[4];
      int srv[4];
      int bad;
      logic [3:0] em_prev;

      // Reset state
      #1 reset = 1'b0;
      #1 check("reset_state", {emergency, served, starved} === 12'h0,
               $sformatf("%h", {emergency, served, starved}), "000");
      tick(3);
      reset = 1'b1;
      tick(1);
      mon_en = 1'b1;

      // Debounce reject on road 1, then a full debounce and service
      siren = 4'b0010;
      tick(2);
      siren = 4'b0000;
      tick(1);
      siren = 4'b0010;
      e = edge_cnt;
      expect_at(e + 3, 4'b0010, 4'b0000, 4'b0000);
      tick(3);
      siren = 4'b0000;
      path  = 2'd1;
      e = edge_cnt;
      expect_at(e + 4, 4'b0000, 4'b0010, 4'b0000);
      expect_at(e + 5, 4'b0000, 4'b0000, 4'b0000);
      tick(4);
      path = 2'd0;
      tick(12);

      // Normal service on road 2 with siren held through cooldown
      siren = 4'b0100;
      e = edge_cnt;
      expect_at(e + 3, 4'b0100, 4'b0000, 4'b0000);
      tick(3);
      path = 2'd2;
      s = edge_cnt + 4;
      expect_at(s, 4'b0000, 4'b0100, 4'b0000);
      expect_at(s + 1, 4'b0000, 4'b0000, 4'b0000);
      expect_at(s + 11, 4'b0100, 4'b0000, 4'b0000);
      expect_at(s + 15, 4'b0000, 4'b0100, 4'b0000);
      expect_at(s + 16, 4'b0000, 4'b0000, 4'b0000);
      tick(4);
      path = 2'd0;
      tick(11);
      siren = 4'b0000;
      path  = 2'd2;
      tick(4);
      path = 2'd0;
      tick(12);

      // Interrupted grant on road 0
      siren = 4'b0001;
      path  = 2'd1;
      e = edge_cnt;
      expect_at(e + 3, 4'b0001, 4'b0000, 4'b0000);
      tick(3);
      siren = 4'b0000;
      path  = 2'd0;
      tick(3);
      path = 2'd1;
      tick(1);
      path = 2'd0;
      e = edge_cnt;
      expect_at(e + 4, 4'b0000, 4'b0001, 4'b0000);
      expect_at(e + 5, 4'b0000, 4'b0000, 4'b0000);
      tick(4);
      tick(12);

      // Starvation on road 3, clear coinciding with saturation, later clear, then service
      siren = 4'b1000;
      path  = 2'd0;
      e = edge_cnt + 3;
      expect_at(e, 4'b1000, 4'b0000, 4'b0000);
      expect_at(e + 20, 4'b1000, 4'b0000, 4'b1000);
      expect_at(e + 22, 4'b1000, 4'b0000, 4'b0000);
      expect_at(e + 26, 4'b0000, 4'b1000, 4'b0000);
      expect_at(e + 27, 4'b0000, 4'b0000, 4'b0000);
      tick(3);
      siren = 4'b0000;
      tick(19);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      tick(1);
      clr = 1'b1;
      tick(1);
      clr  = 1'b0;
      path = 2'd3;
      tick(4);
      path = 2'd0;
      tick(12);

      // All roads pending, road 1 in service, then asynchronous reset
      siren = 4'b1111;
      path  = 2'd1;
      e = edge_cnt;
      expect_at(e + 3, 4'b1111, 4'b0000, 4'b0000);
      tick(4);
      mon_en = 1'b0;
      #2 reset = 1'b0;
      #1 check("async_reset", {emergency, served, starved} === 12'h0,
               $sformatf("%h", {emergency, served, starved}), "000");
      siren = 4'b0000;
      tick(2);
      reset = 1'b1;
      tick(2);
      check("expected_events_seen", q.size() == 0, $sformatf("%0d left", q.size()), "0 left");

      // Soak with a simple hold-until-served grant model
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         rises[i] = 0;
         srv[i]   = 0;
      end
      em_prev = emergency;
      for (int c = 0; c < 1060; c++) begin
         @(negedge clk);
         if (c < 1000 && c % 100 == 0) siren = 4'($urandom_range(0, 15));
         if (c == 1000) siren = 4'b0000;
         for (int i = 0; i < 4; i++) begin
            if (emergency[i] && !em_prev[i]) rises[i]++;
            if (served[i]) begin
               srv[i]++;
               if (!em_prev[i]) bad++;
            end
         end
         em_prev = emergency;
         if (!emergency[path]) begin
            for (int k = 1; k <= 4; k++) begin
               if (emergency[(int'(path) + k) % 4]) begin
                  path = 2'((int'(path) + k) % 4);
                  break;
               end
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         check($sformatf("soak_served_road%0d", i), srv[i] == rises[i],
               $sformatf("%0d served", srv[i]), $sformatf("%0d requests", rises[i]));
      end
      check("soak_served_without_request", bad == 0, $sformatf("%0d", bad), "0");
      check("soak_final_idle", emergency === 4'b0000, $sformatf("%b", emergency), "0000");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/emergency_request_ctrl.md
# emergency_request_ctrl

Front-end request generator for `traffic_simulation`. Debounces the four per-road siren detector inputs and drives the controller's `emergency[3:0]` input with one latched request per road. Each request is withdrawn only after the controller has held that road on `current_free_path` for a minimum service time. The block also flags roads whose request has waited too long.

## Interface
- `NUM_ROADS`, 4: number of roads; fixed at 4 because `current_free_path` is 2 bits.
- `DEBOUNCE_CYC`, 3: consecutive high siren samples required to raise a request; must be ≥1.
- `HOLD_CYC`, 4: consecutive cycles the road must be granted before its request is considered served; must be ≥1.
- `COOLDOWN_CYC`, 8: cycles after service during which the road's siren is ignored; 0 is allowed.
- `TIMEOUT_CYC`, 200: wait cycles after which a road is flagged starved; must be ≥1.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous assert, active-low.
- `siren` input 4: raw per-road detector levels, synchronous to `clk`.
- `current_free_path` input 2: road currently granted by `traffic_simulation`.
- `clear_starved` input 1: clears all `starved` flags.
- `emergency` output 4: registered per-road request, wired to `traffic_simulation.emergency`.
- `served` output 4: one-cycle pulse per road when its service completes.
- `starved` output 4: sticky per-road timeout flag.

## Operation
- There is one independent lane per road `i`, and each lane is a 5-state FSM.
  - **IDLE**
    - `siren[i]`=1: go to DBNC with `dcnt`=1.
    - If `DEBOUNCE_CYC`=1: go directly to PEND.
  - **DBNC**
    - `siren[i]`=0: return to IDLE.
    - Otherwise `dcnt`++. When `dcnt` reaches `DEBOUNCE_CYC`, go to PEND and load `wcnt`=0.
  - **PEND**
    - `current_free_path`==i: go to SERV with `hcnt`=1.
    - If `HOLD_CYC`=1: finish service immediately, as described at the end of SERV.
  - **SERV**
    - `current_free_path`≠i: return to PEND. `hcnt` is discarded. `wcnt` is not reset.
    - Otherwise `hcnt`++. When `hcnt` reaches `HOLD_CYC`, pulse `served[i]` and go to COOL with `ccnt`=0. If `COOLDOWN_CYC`=0, go to IDLE instead.
  - **COOL**
    - `siren[i]` is ignored.
    - `ccnt`++ each cycle. When `ccnt` reaches `COOLDOWN_CYC`, go to IDLE.
- `emergency[i]` = 1 exactly while the lane state is PEND or SERV. It is a registered decode of the next state, so there is no combinational path from inputs.
- **Wait counter `wcnt`**
  - Increments every cycle in PEND or SERV and saturates at `TIMEOUT_CYC`.
  - On the cycle it reaches `TIMEOUT_CYC`, `starved[i]` is set.
- **`starved[i]`**
  - Stays set until a cycle with `clear_starved`=1.
  - If set and clear occur in the same cycle, set wins.
  - Is not cleared by service.
- A siren that remains high through COOL re-enters DBNC on the first IDLE cycle. A full debounce is required again.
- Lanes do not interact. Several `emergency` bits may be high simultaneously; arbitration among them belongs to `traffic_simulation`.
- **Counter widths:** `$clog2(P+1)` of the respective parameter. `wcnt` saturates and never wraps.

## Timing
- **Reset values:** all lanes IDLE, all counters 0, `emergency`=0, `served`=0, `starved`=0. Reset mid-service drops every request immediately with no `served` pulse.
- **Request latency:** `siren[i]` sampled high on edges k … k+`DEBOUNCE_CYC`−1 gives `emergency[i]`=1 after edge k+`DEBOUNCE_CYC`−1.
- **Release latency:** grant sampled on `HOLD_CYC` consecutive edges gives `emergency[i]`=0 and `served[i]`=1 after the last of those edges. `served[i]` returns to 0 one edge later.
- **Starvation latency:** `starved[i]` rises `TIMEOUT_CYC` edges after `emergency[i]` rose, provided the lane has not returned to IDLE or COOL.

## Structure
- **Package `traffic_pkg`:**
  - `lane_state_t` enum {IDLE, DBNC, PEND, SERV, COOL}.
  - `NUM_ROADS`.
  - Road index constants `ROAD0`..`ROAD3`.
  - The shared `GO_MODE`/`CAUTION_MODE` enum used by `traffic_simulation` moves into this package as well.
- **Sub-module `emergency_lane`:**
  - Holds one FSM, its counters and its starved flag.
  - Has a parameter for its road index.
  - Instantiated 4× by a generate loop in `emergency_request_ctrl`.

## Test plan
- **Debounce reject:** `siren[1]` high 2 cycles then low → `emergency` stays 0. Then high 3 cycles → `emergency[1]` rises after the 3rd edge.
- **Normal service:** pending road 2, `current_free_path`=2 for 4 cycles → `served[2]` single pulse, `emergency[2]` low on the same edge. `siren[2]` held high during COOL → `emergency[2]` stays 0 for 8 cycles, then rises again after 3 more.
- **Interrupted grant:** path=0 for 3 cycles, then 1, then 0 for 4 → `emergency[0]` remains high until the 4th consecutive grant. Exactly one `served[0]` pulse.
- **Starvation:** `TIMEOUT_CYC`=20, road 3 pending with no grant → `starved[3]` rises 20 edges after `emergency[3]`. `clear_starved` pulsed in the same cycle that `wcnt` saturates → flag remains 1.
- **Reset mid-operation:** all four roads pending, road 1 in SERV. Assert `reset` asynchronously → `emergency`, `served`, `starved` go to 0 without waiting for a clock edge.
- **Random soak against `traffic_simulation`:** random `siren` (0–15) every 100 cycles → every raised `emergency` bit eventually produces exactly one `served` pulse. No `served` pulse occurs without prior `emergency`.
